regfile_bypass: RTL



---
 rtl/regfile_bypass_if.sv | 17 +
 rtl/regfile_bypass.sv | 91 +++++++++
 2 files changed

// File: rtl/regfile_bypass_if.sv
// Write/read bus of the decode-stage register file: one write port, two read ports and the ready flag.
interface regfile_bypass_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] wa;
   logic [DATA_WIDTH-1:0] wd;
   logic [ADDR_WIDTH-1:0] ra1;
   logic [ADDR_WIDTH-1:0] ra2;
   logic [DATA_WIDTH-1:0] rd1;
   logic [DATA_WIDTH-1:0] rd2;
   logic                  ready;

   modport master (output we, wa, wd, ra1, ra2, input rd1, rd2, ready);
   modport slave  (input we, wa, wd, ra1, ra2, output rd1, rd2, ready);
endinterface

// File: rtl/regfile_bypass.sv
// Parametrised register file with two async read ports, one sync write port, optional zero
// register, optional write-to-read bypass and a post-reset clear sweep.
module regfile_bypass #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input logic            clk,
   input logic            rst,
   regfile_bypass_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_clrIdx;
   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_wrDrop;
   logic                  w_runWrite;
   logic [DATA_WIDTH-1:0] w_rd1;
   logic [DATA_WIDTH-1:0] w_rd2;

   assign w_wrDrop   = (ZERO_REG != 0) && (bus.wa == '0);
   assign w_runWrite = (r_state == RUN) && bus.we && !w_wrDrop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= CLEAR;
         r_clrIdx <= '0;
         r_ready  <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_clrIdx <= r_clrIdx + 1'b1;
               if (&r_clrIdx) begin
                  r_state <= RUN;
                  r_ready <= 1'b1;
               end
            end
            RUN: begin
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= CLEAR;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // The array has no reset of its own; the sweep zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == CLEAR) begin
            r_mem[r_clrIdx] <= '0;
         end else if (w_runWrite) begin
            r_mem[bus.wa] <= bus.wd;
         end
      end
   end

   always_comb begin
      w_rd1 = r_mem[bus.ra1];
      if (r_state != RUN) begin
         w_rd1 = '0;
      end else if ((ZERO_REG != 0) && (bus.ra1 == '0)) begin
         w_rd1 = '0;
      end else if ((BYPASS != 0) && w_runWrite && (bus.wa == bus.ra1)) begin
         w_rd1 = bus.wd;
      end
   end

   always_comb begin
      w_rd2 = r_mem[bus.ra2];
      if (r_state != RUN) begin
         w_rd2 = '0;
      end else if ((ZERO_REG != 0) && (bus.ra2 == '0)) begin
         w_rd2 = '0;
      end else if ((BYPASS != 0) && w_runWrite && (bus.wa == bus.ra2)) begin
         w_rd2 = bus.wd;
      end
   end

   assign bus.rd1   = w_rd1;
   assign bus.rd2   = w_rd2;
   assign bus.ready = r_ready;
endmodule
